// File: rtl/crypto_dma_pkg.sv
// rtl/crypto_dma_pkg.sv - shared types, register indices and bit positions for the crypto DMA
package crypto_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_CSTART = 3'd2,
        ST_CWAIT  = 3'd3,
        ST_WR     = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    typedef enum logic {
        MODE_ECB = 1'b0,
        MODE_CBC = 1'b1
    } mode_e;

    localparam int IDX_KEY = 0;

    localparam int CTRL_START  = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_ABORT  = 3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_ABORTED   = 2;
    localparam int STAT_COUNT_LSB = 16;

    // Register layout follows the key and IV word counts: KEY, IV, SRC, DST, NUM, CTRL, STATUS.
    function automatic int idx_iv(input int key_words);
        return key_words;
    endfunction

    function automatic int idx_src(input int key_words, input int blk_words);
        return key_words + blk_words;
    endfunction

endpackage

// File: rtl/crypto_dma_regs.sv
// rtl/crypto_dma_regs.sv - target register file with busy write-protect, W1C status and CTRL pulses
module crypto_dma_regs
    import crypto_dma_pkg::*;
#(
    parameter int DW    = 32,
    parameter int BLK_W = 64,
    parameter int KEY_W = 128,
    parameter int AW    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             avs_write,
    input  logic [5:0]       avs_address,
    input  logic [DW-1:0]    avs_writedata,
    output logic [DW-1:0]    avs_readdata,
    input  logic             busy,
    input  logic             set_done,
    input  logic             set_aborted,
    input  logic [15:0]      count,
    output logic [KEY_W-1:0] key,
    output logic [BLK_W-1:0] iv,
    output logic [AW-1:0]    src,
    output logic [AW-1:0]    dst,
    output logic [DW-1:0]    num,
    output mode_e            mode,
    output logic             start,
    output logic             abort,
    output logic             irq
);

    localparam int KW         = KEY_W / DW;
    localparam int BW         = BLK_W / DW;
    localparam int IDX_IV     = idx_iv(KW);
    localparam int IDX_SRC    = idx_src(KW, BW);
    localparam int IDX_DST    = IDX_SRC + 1;
    localparam int IDX_NUM    = IDX_SRC + 2;
    localparam int IDX_CTRL   = IDX_SRC + 3;
    localparam int IDX_STATUS = IDX_SRC + 4;

    logic [KEY_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] iv_q, iv_d;
    logic [AW-1:0]    src_q, src_d, dst_q, dst_d;
    logic [DW-1:0]    num_q, num_d;
    mode_e            mode_q, mode_d;
    logic             irq_en_q, irq_en_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic [3:0]       widx;

    assign widx = avs_address[5:2];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_q     <= '0;
            iv_q      <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            num_q     <= '0;
            mode_q    <= MODE_ECB;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            key_q     <= key_d;
            iv_q      <= iv_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            num_q     <= num_d;
            mode_q    <= mode_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        key_d     = key_q;
        iv_d      = iv_q;
        src_d     = src_q;
        dst_d     = dst_q;
        num_d     = num_q;
        mode_d    = mode_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        start     = 1'b0;
        abort     = 1'b0;
        if (avs_write) begin
            for (int i = 0; i < KW; i++) begin
                if (!busy && widx == 4'(IDX_KEY + i)) key_d[i*DW +: DW] = avs_writedata;
            end
            for (int i = 0; i < BW; i++) begin
                if (!busy && widx == 4'(IDX_IV + i)) iv_d[i*DW +: DW] = avs_writedata;
            end
            if (!busy && widx == 4'(IDX_SRC)) src_d = avs_writedata[AW-1:0];
            if (!busy && widx == 4'(IDX_DST)) dst_d = avs_writedata[AW-1:0];
            if (!busy && widx == 4'(IDX_NUM)) num_d = avs_writedata;
            if (widx == 4'(IDX_CTRL)) begin
                irq_en_d = avs_writedata[CTRL_IRQ_EN];
                if (!busy) begin
                    mode_d = mode_e'(avs_writedata[CTRL_MODE]);
                    start  = avs_writedata[CTRL_START];
                end
                abort = busy & avs_writedata[CTRL_ABORT];
            end
            if (widx == 4'(IDX_STATUS)) begin
                if (avs_writedata[STAT_DONE])    done_d    = 1'b0;
                if (avs_writedata[STAT_ABORTED]) aborted_d = 1'b0;
            end
        end
        // A completion event in the same cycle as a W1C write must not be lost.
        if (set_done)    done_d    = 1'b1;
        if (set_aborted) aborted_d = 1'b1;
    end

    always_comb begin
        avs_readdata = '0;
        for (int i = 0; i < KW; i++) begin
            if (widx == 4'(IDX_KEY + i)) avs_readdata = key_q[i*DW +: DW];
        end
        for (int i = 0; i < BW; i++) begin
            if (widx == 4'(IDX_IV + i)) avs_readdata = iv_q[i*DW +: DW];
        end
        if (widx == 4'(IDX_SRC)) avs_readdata[AW-1:0] = src_q;
        if (widx == 4'(IDX_DST)) avs_readdata[AW-1:0] = dst_q;
        if (widx == 4'(IDX_NUM)) avs_readdata = num_q;
        if (widx == 4'(IDX_CTRL)) begin
            avs_readdata[CTRL_MODE]   = mode_q;
            avs_readdata[CTRL_IRQ_EN] = irq_en_q;
        end
        if (widx == 4'(IDX_STATUS)) begin
            avs_readdata[STAT_BUSY]              = busy;
            avs_readdata[STAT_DONE]              = done_q;
            avs_readdata[STAT_ABORTED]           = aborted_q;
            avs_readdata[STAT_COUNT_LSB +: 16]   = count;
        end
    end

    assign key  = key_q;
    assign iv   = iv_q;
    assign src  = src_q;
    assign dst  = dst_q;
    assign num  = num_q;
    assign mode = mode_q;
    assign irq  = irq_en_q & (done_q | aborted_q);

endmodule

// File: rtl/avalon_crypto_dma.sv
// rtl/avalon_crypto_dma.sv - Avalon-MM block-cipher DMA: read block, run cipher core, write result
module avalon_crypto_dma
    import crypto_dma_pkg::*;
#(
    parameter int DW    = 32,
    parameter int BLK_W = 64,
    parameter int KEY_W = 128,
    parameter int AW    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             avs_write,
    input  logic [5:0]       avs_address,
    input  logic [DW-1:0]    avs_writedata,
    output logic [DW-1:0]    avs_readdata,
    output logic             avm_read,
    output logic             avm_write,
    input  logic             avm_waitrequest,
    output logic [AW-1:0]    avm_address,
    output logic [DW-1:0]    avm_writedata,
    input  logic [DW-1:0]    avm_readdata,
    output logic             cph_start,
    output logic [BLK_W-1:0] cph_din,
    output logic [KEY_W-1:0] cph_key,
    input  logic             cph_eoc,
    input  logic [BLK_W-1:0] cph_dout,
    output logic             irq
);

    localparam int BW = BLK_W / DW;
    localparam int CW = (BW > 1) ? $clog2(BW) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    beat_q, beat_d;
    logic [AW-1:0]    src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
    logic [DW-1:0]    remaining_q, remaining_d;
    logic [BLK_W-1:0] chain_q, chain_d, blk_q, blk_d;
    logic [15:0]      count_q, count_d;
    logic             abort_pend_q, abort_pend_d;

    logic [BLK_W-1:0] r_iv;
    logic [AW-1:0]    r_src, r_dst;
    logic [DW-1:0]    r_num;
    mode_e            r_mode;
    logic             r_start, r_abort, busy, set_done, set_aborted;
    logic             beat_last, accepted;

    crypto_dma_regs #(.DW(DW), .BLK_W(BLK_W), .KEY_W(KEY_W), .AW(AW)) u_regs (
        .clk          (clk),
        .reset_n      (reset_n),
        .avs_write    (avs_write),
        .avs_address  (avs_address),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .busy         (busy),
        .set_done     (set_done),
        .set_aborted  (set_aborted),
        .count        (count_q),
        .key          (cph_key),
        .iv           (r_iv),
        .src          (r_src),
        .dst          (r_dst),
        .num          (r_num),
        .mode         (r_mode),
        .start        (r_start),
        .abort        (r_abort),
        .irq          (irq)
    );

    assign beat_last = (beat_q == CW'(BW - 1));
    assign accepted  = !avm_waitrequest;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remaining_q  <= '0;
            chain_q      <= '0;
            blk_q        <= '0;
            count_q      <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remaining_q  <= remaining_d;
            chain_q      <= chain_d;
            blk_q        <= blk_d;
            count_q      <= count_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (r_start) state_d = (r_num == '0) ? ST_FIN : ST_RD;
            ST_RD:     if (accepted && beat_last) state_d = ST_CSTART;
            ST_CSTART: state_d = ST_CWAIT;
            ST_CWAIT:  if (cph_eoc) state_d = ST_WR;
            ST_WR: begin
                // Abort is only honoured here, once the current block has been fully written.
                if (accepted && beat_last)
                    state_d = (remaining_q == '0 || abort_pend_q || r_abort) ? ST_FIN : ST_RD;
            end
            ST_FIN:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        beat_d       = beat_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        remaining_d  = remaining_q;
        chain_d      = chain_q;
        blk_d        = blk_q;
        count_d      = count_q;
        abort_pend_d = abort_pend_q | r_abort;
        case (state_q)
            ST_IDLE: begin
                if (r_start) begin
                    src_ptr_d    = r_src;
                    dst_ptr_d    = r_dst;
                    remaining_d  = r_num;
                    chain_d      = r_iv;
                    count_d      = '0;
                    beat_d       = '0;
                    abort_pend_d = 1'b0;
                end
            end
            ST_RD: begin
                if (accepted) begin
                    blk_d[beat_q*DW +: DW] = avm_readdata;
                    src_ptr_d = src_ptr_q + AW'(DW / 8);
                    beat_d    = beat_last ? '0 : beat_q + CW'(1);
                end
            end
            ST_CWAIT: begin
                if (cph_eoc) begin
                    blk_d       = cph_dout;
                    chain_d     = cph_dout;
                    count_d     = count_q + 16'd1;
                    remaining_d = remaining_q - DW'(1);
                end
            end
            ST_WR: begin
                if (accepted) begin
                    dst_ptr_d = dst_ptr_q + AW'(DW / 8);
                    beat_d    = beat_last ? '0 : beat_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy          = (state_q != ST_IDLE);
        avm_read      = (state_q == ST_RD);
        avm_write     = (state_q == ST_WR);
        avm_address   = '0;
        avm_writedata = '0;
        if (state_q == ST_RD) avm_address = src_ptr_q;
        if (state_q == ST_WR) begin
            avm_address   = dst_ptr_q;
            avm_writedata = blk_q[beat_q*DW +: DW];
        end
        cph_start   = (state_q == ST_CSTART);
        cph_din     = (r_mode == MODE_CBC) ? (blk_q ^ chain_q) : blk_q;
        set_done    = (state_q == ST_FIN) && !abort_pend_q;
        set_aborted = (state_q == ST_FIN) && abort_pend_q;
    end

endmodule
